spi_adc_responder: RTL and testbench

SPI_ADC_RESPONDER -- requirements
Module: spi_adc_responder

---
 rtl/spi_adc_responder_if.sv | 13 +
 rtl/spi_adc_responder.sv | 155 +++++++++++++++
 tb/tb_spi_adc_responder.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_adc_responder_if.sv
// SPI pin bundle between an initiator and the ADC responder.
// Latency: none, wires only.
// Backpressure: none; SPI has no flow control, the initiator owns SCK/CS.
interface spi_adc_responder_if;
    logic SCK;
    logic CS;
    logic MOSI;
    logic MISO;
    logic miso_oe;

    modport master (output SCK, output CS, output MOSI, input MISO, input miso_oe);
    modport slave  (input SCK, input CS, input MOSI, output MISO, output miso_oe);
endinterface

// File: rtl/spi_adc_responder.sv
// Mode-0 SPI responder returning a loaded ADC sample and capturing the MOSI word.
// Latency: SCK fall at the pin to MISO update is SYNC_STAGES+2 clk cycles.
// Backpressure: none; loads during a frame are held pending until the frame ends.
module spi_adc_responder #(
    parameter int DATA_W      = 12,
    parameter int FRAME_LEN   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    spi_adc_responder_if.slave   spi,
    input  logic [DATA_W-1:0]    i_data,
    input  logic                 i_load,
    output logic [FRAME_LEN-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 busy,
    output logic                 frame_err
);
    localparam int CNT_W = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_LEN);

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    state_t state, state_nx;

    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
    logic                   sck_d, cs_d;
    logic                   sck_s, cs_s, mosi_s;
    logic                   sck_rise, sck_fall, cs_rise, cs_fall;
    logic                   primed, armed, fall_pend, start;

    logic [DATA_W-1:0]      sample_reg, pending_reg;
    logic                   pending;
    logic [CNT_W-1:0]       bit_cnt;
    logic [FRAME_LEN-1:0]   tx_shift, rx_shift;
    logic                   miso_q, oe_q;

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;
    assign cs_rise  = cs_s & ~cs_d;
    assign cs_fall  = ~cs_s & cs_d;

    // A CS fall is only trusted once CS has been seen high on a real pin sample
    // after reset; a fall seen in DONE is replayed in IDLE while CS stays low.
    assign start = armed & (cs_fall | (fall_pend & ~cs_s));

    assign spi.MISO    = miso_q;
    assign spi.miso_oe = oe_q;
    assign busy        = (state == ACTIVE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sck_d     <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sck_sync  <= (sck_sync << 1) | SYNC_STAGES'(spi.SCK);
            cs_sync   <= (cs_sync << 1) | SYNC_STAGES'(spi.CS);
            mosi_sync <= (mosi_sync << 1) | SYNC_STAGES'(spi.MOSI);
            sck_d     <= sck_s;
            cs_d      <= cs_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = ACTIVE;
            ACTIVE:  if (cs_rise) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            primed      <= 1'b0;
            armed       <= 1'b0;
            fall_pend   <= 1'b0;
            sample_reg  <= '0;
            pending_reg <= '0;
            pending     <= 1'b0;
            bit_cnt     <= '0;
            tx_shift    <= '0;
            rx_shift    <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            miso_q      <= 1'b0;
            oe_q        <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            primed    <= 1'b1;
            if (primed && cs_sync[0]) armed <= 1'b1;
            fall_pend <= (state == DONE) && cs_fall;

            case (state)
                IDLE: begin
                    miso_q <= 1'b0;
                    if (i_load) sample_reg <= i_data;
                    if (start) begin
                        tx_shift <= FRAME_LEN'(i_load ? i_data : sample_reg);
                        bit_cnt  <= '0;
                        oe_q     <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (i_load) begin
                        pending_reg <= i_data;
                        pending     <= 1'b1;
                    end
                    if (bit_cnt != CNT_FULL) begin
                        if (sck_rise) begin
                            rx_shift <= (rx_shift << 1) | FRAME_LEN'(mosi_s);
                            bit_cnt  <= bit_cnt + CNT_W'(1);
                        end
                        if (sck_fall) tx_shift <= tx_shift << 1;
                        miso_q <= tx_shift[FRAME_LEN-1];
                    end else begin
                        miso_q <= 1'b0;
                    end
                end
                DONE: begin
                    if (bit_cnt == CNT_FULL) begin
                        rx_data  <= rx_shift;
                        rx_valid <= 1'b1;
                    end else begin
                        frame_err <= 1'b1;
                    end
                    // A load arriving in DONE is newer than anything pending.
                    if (i_load) sample_reg <= i_data;
                    else if (pending) sample_reg <= pending_reg;
                    pending <= 1'b0;
                    oe_q    <= 1'b0;
                    miso_q  <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_adc_responder.sv
// Randomized bench for spi_adc_responder: drives mode-0 frames at clk/10 and
// compares MISO stream, rx_data and pulse counts against a frame-level model.
module tb_spi_adc_responder;
    localparam int DW = 12;
    localparam int FL = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] i_data;
    logic          i_load;
    logic [FL-1:0] rx_data;
    logic          rx_valid, busy, frame_err;

    always #5 clk = ~clk;

    spi_adc_responder_if spi ();

    spi_adc_responder #(.DATA_W(DW), .FRAME_LEN(FL), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .spi       (spi),
        .i_data    (i_data),
        .i_load    (i_load),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .busy      (busy),
        .frame_err (frame_err)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int rv_cnt = 0;
    int fe_cnt = 0;

    logic [DW-1:0] m_sample;
    logic [DW-1:0] m_pend_val;
    bit            m_pend;
    logic [FL-1:0] m_rx;

    always @(negedge clk) begin
        if (rx_valid === 1'b1) rv_cnt++;
        if (frame_err === 1'b1) fe_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_idle(input logic [DW-1:0] v);
        i_data = v;
        i_load = 1'b1;
        wait_clk(1);
        i_load = 1'b0;
        m_sample = v;
        wait_clk(2);
    endtask

    task automatic sck_pulses(input int n);
        for (int k = 0; k < n; k++) begin
            spi.SCK = 1'b1;
            wait_clk(5);
            spi.SCK = 1'b0;
            wait_clk(5);
        end
    endtask

    // mosi_bits[31] is the first bit on the wire; load_at < 0 means no mid-frame load.
    task automatic run_frame(input int nbits, input logic [31:0] mosi_bits, input int load_at,
                             input logic [DW-1:0] load_val, input bit cs_load);
        logic [31:0]   cap;
        logic [31:0]   exp_miso;
        logic [FL-1:0] tx;
        logic          busy_mid, oe_mid;
        int            rv0, fe0;

        if (cs_load) m_sample = load_val;
        tx       = FL'(m_sample);
        cap      = '0;
        exp_miso = '0;
        rv0      = rv_cnt;
        fe0      = fe_cnt;

        spi.MOSI = mosi_bits[31];
        spi.CS   = 1'b0;
        if (cs_load) begin
            wait_clk(2);
            i_data = load_val;
            i_load = 1'b1;
            wait_clk(1);
            i_load = 1'b0;
            wait_clk(3);
        end else begin
            wait_clk(6);
        end
        busy_mid = busy;
        oe_mid   = spi.miso_oe;

        for (int i = 0; i < nbits; i++) begin
            cap      = {cap[30:0], spi.MISO};
            exp_miso = {exp_miso[30:0], (i < FL) ? tx[FL-1-i] : 1'b0};
            spi.SCK  = 1'b1;
            wait_clk(5);
            spi.SCK  = 1'b0;
            if (i < 31) spi.MOSI = mosi_bits[30-i];
            if (i == load_at) begin
                i_data = load_val;
                i_load = 1'b1;
                wait_clk(1);
                i_load = 1'b0;
                m_pend = 1'b1;
                m_pend_val = load_val;
                wait_clk(4);
            end else begin
                wait_clk(5);
            end
        end

        spi.CS = 1'b1;
        wait_clk(10);

        chk("busy_in_frame", 32'(busy_mid), 32'd1);
        chk("oe_in_frame", 32'(oe_mid), 32'd1);
        chk("miso_stream", cap, exp_miso);
        if (nbits >= FL) begin
            m_rx = mosi_bits[31:32-FL];
            chk("rx_valid_count", 32'(rv_cnt - rv0), 32'd1);
            chk("frame_err_count", 32'(fe_cnt - fe0), 32'd0);
        end else begin
            chk("rx_valid_count", 32'(rv_cnt - rv0), 32'd0);
            chk("frame_err_count", 32'(fe_cnt - fe0), 32'd1);
        end
        chk("rx_data", 32'(rx_data), 32'(m_rx));
        chk("idle_outputs", 32'({busy, spi.miso_oe, spi.MISO}), 32'd0);
        if (m_pend) m_sample = m_pend_val;
        m_pend = 1'b0;
    endtask

    initial begin
        int rv0, fe0, nb, sel, la;

        rst_n    = 1'b0;
        spi.CS   = 1'b1;
        spi.SCK  = 1'b0;
        spi.MOSI = 1'b0;
        i_data   = '0;
        i_load   = 1'b0;
        m_sample = '0;
        m_pend   = 1'b0;
        m_pend_val = '0;
        m_rx     = '0;

        wait_clk(3);
        chk("reset_outputs", 32'({spi.MISO, spi.miso_oe, busy, rx_valid, frame_err, rx_data}), 32'd0);
        rst_n = 1'b1;
        wait_clk(3);

        // Basic frame, pending-load ordering, short, long.
        load_idle(12'hABC);
        run_frame(16, 32'h1800_0000, -1, '0, 1'b0);
        run_frame(16, $urandom, 7, 12'h123, 1'b0);
        run_frame(16, $urandom, -1, '0, 1'b0);
        run_frame(9, $urandom, -1, '0, 1'b0);
        run_frame(20, $urandom, -1, '0, 1'b0);

        // Reset in the middle of a frame, then CS left low after release.
        rv0 = rv_cnt;
        fe0 = fe_cnt;
        spi.MOSI = 1'b1;
        spi.CS   = 1'b0;
        wait_clk(6);
        sck_pulses(5);
        rst_n = 1'b0;
        wait_clk(3);
        chk("mid_reset_outputs", 32'({spi.MISO, spi.miso_oe, busy, rx_valid, frame_err, rx_data}), 32'd0);
        rst_n = 1'b1;
        wait_clk(4);
        sck_pulses(3);
        chk("post_reset_idle", 32'({busy, spi.miso_oe, spi.MISO}), 32'd0);
        spi.CS = 1'b1;
        wait_clk(10);
        chk("reset_no_pulses", 32'((rv_cnt - rv0) + (fe_cnt - fe0)), 32'd0);
        m_sample = '0;
        m_pend   = 1'b0;
        m_rx     = '0;
        run_frame(16, $urandom, -1, '0, 1'b0);

        // Load coinciding with the detected CS fall.
        run_frame(16, $urandom, -1, 12'h7FF, 1'b1);

        for (int f = 0; f < 30; f++) begin
            if ($urandom_range(0, 1) == 1) load_idle(DW'($urandom));
            sel = $urandom_range(0, 3);
            if (sel == 0) nb = $urandom_range(0, 15);
            else if (sel == 1) nb = $urandom_range(17, 20);
            else nb = 16;
            la = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nb) : -1;
            run_frame(nb, $urandom, la, DW'($urandom), $urandom_range(0, 5) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
